// File: rtl/snn_input_loader.sv
// Image input stage of the SNN core: unpacks received bytes into a 1-bit pixel RAM, starts the core, returns the digit.
// Optional build macro SNN_ASCII_DIGIT_EN: when defined the result digit is sent as an ASCII character.
module snn_input_loader #(
   parameter int NUM_PIXELS = 784,
   parameter int ADDR_W     = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx_rdy,
   input  logic [7:0]        rx_data,
   input  logic [ADDR_W-1:0] addr_input_unit,
   output logic              q_input,
   output logic              start,
   input  logic              core_done,
   input  logic [3:0]        digit,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   input  logic              tx_done,
   output logic              busy,
   output logic              ovr
);

   localparam int         NUM_BYTES = NUM_PIXELS / 8;
   localparam logic [6:0] LAST_BYTE = 7'(NUM_BYTES - 1);

   typedef enum logic [2:0] {
      LOAD    = 3'd0,
      UNPACK  = 3'd1,
      START   = 3'd2,
      RUN     = 3'd3,
      SEND    = 3'd4,
      WAIT_TX = 3'd5
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [6:0]        byte_cnt;
   logic [2:0]        bit_cnt;
   logic [7:0]        shift;
   logic [7:0]        hold_buf;
   logic              hold_full;
   logic [7:0]        digit_byte;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W-1:0] rd_addr;
   logic              last_bit;
   logic              frame_done;

   logic ram [0:(1<<ADDR_W)-1];

`ifdef SNN_ASCII_DIGIT_EN
   assign digit_byte = 8'h30 + {4'h0, digit};
`else
   assign digit_byte = {4'h0, digit};
`endif

   // Pixel 8k+b lives at {byte k, bit b}, so the write address is just the two counters.
   assign wr_addr    = ADDR_W'({byte_cnt, bit_cnt});
   assign rd_addr    = (state == RUN) ? addr_input_unit : wr_addr;
   assign last_bit   = (bit_cnt == 3'd7);
   assign frame_done = last_bit && (byte_cnt == LAST_BYTE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= LOAD;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         LOAD: begin
            if (rx_rdy) state_next = UNPACK;
         end
         UNPACK: begin
            // A byte arriving on the last bit chains straight into the next unpack.
            if (frame_done)                       state_next = START;
            else if (last_bit && !hold_full && !rx_rdy) state_next = LOAD;
         end
         START:   state_next = RUN;
         RUN: begin
            if (core_done) state_next = SEND;
         end
         SEND:    state_next = WAIT_TX;
         WAIT_TX: begin
            if (tx_done) state_next = LOAD;
         end
         default: state_next = LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_cnt  <= 7'd0;
         bit_cnt   <= 3'd0;
         shift     <= 8'h00;
         hold_buf  <= 8'h00;
         hold_full <= 1'b0;
         start     <= 1'b0;
         tx_start  <= 1'b0;
         tx_data   <= 8'h00;
         busy      <= 1'b0;
         ovr       <= 1'b0;
      end else begin
         start    <= (state_next == START);
         tx_start <= (state == SEND);
         busy     <= (state_next != LOAD);
         case (state)
            LOAD: begin
               if (rx_rdy) begin
                  shift   <= rx_data;
                  bit_cnt <= 3'd0;
                  if (byte_cnt == 7'd0) ovr <= 1'b0;
               end
            end
            UNPACK: begin
               shift   <= {1'b0, shift[7:1]};
               bit_cnt <= bit_cnt + 3'd1;
               if (frame_done) begin
                  // Anything still held or arriving now belongs to no frame.
                  byte_cnt  <= 7'd0;
                  hold_full <= 1'b0;
                  if (rx_rdy) ovr <= 1'b1;
               end else if (last_bit) begin
                  byte_cnt <= byte_cnt + 7'd1;
                  if (hold_full) begin
                     shift     <= hold_buf;
                     hold_full <= 1'b0;
                     if (rx_rdy) ovr <= 1'b1;
                  end else if (rx_rdy) begin
                     shift <= rx_data;
                  end
               end else if (rx_rdy) begin
                  if (hold_full) begin
                     ovr <= 1'b1;
                  end else begin
                     hold_buf  <= rx_data;
                     hold_full <= 1'b1;
                  end
               end
            end
            START, RUN, SEND, WAIT_TX: begin
               if (rx_rdy) ovr <= 1'b1;
               if ((state == RUN) && core_done) tx_data <= digit_byte;
            end
            default: begin
               byte_cnt <= 7'd0;
            end
         endcase
      end
   end

   // Pixel RAM contents survive reset; only the read register is cleared.
   always_ff @(posedge clk) begin
      if (state == UNPACK) ram[wr_addr] <= shift[0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_input <= 1'b0;
      end else begin
         q_input <= ram[rd_addr];
      end
   end

endmodule

// File: tb/tb_snn_input_loader.sv
// Scoreboard bench for snn_input_loader: drivers push expected start/tx/read results, monitors pop and compare.
module tb_snn_input_loader;

   localparam int NUM_BYTES  = 98;
   localparam int NUM_PIXELS = 784;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx_rdy;
   logic [7:0] rx_data;
   logic [9:0] addr_input_unit;
   logic       q_input;
   logic       start;
   logic       core_done;
   logic [3:0] digit;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       tx_done;
   logic       busy;
   logic       ovr;

   snn_input_loader #(.NUM_PIXELS(NUM_PIXELS), .ADDR_W(10)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .rx_rdy          (rx_rdy),
      .rx_data         (rx_data),
      .addr_input_unit (addr_input_unit),
      .q_input         (q_input),
      .start           (start),
      .core_done       (core_done),
      .digit           (digit),
      .tx_start        (tx_start),
      .tx_data         (tx_data),
      .tx_done         (tx_done),
      .busy            (busy),
      .ovr             (ovr)
   );

   // ---------------- clock / cycle counter ----------------
   always #10 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   int          checks = 0;
   int          errors = 0;
   logic [7:0]  img [NUM_BYTES];
   logic [31:0] start_exp_q[$];
   logic [31:0] tx_cyc_q[$];
   logic [7:0]  tx_data_q[$];
   logic [0:0]  q_exp_q[$];
   logic        rd_req = 1'b0;
   logic        rd_pend = 1'b0;
   int          last_rx_cyc = 0;
   logic [31:0] e_cyc;
   logic [7:0]  e_dat;
   logic [0:0]  e_bit;

   function automatic logic [7:0] exp_tx(input logic [3:0] d);
`ifdef SNN_ASCII_DIGIT_EN
      return 8'h30 + {4'h0, d};
`else
      return {4'h0, d};
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- monitors ----------------
   always @(posedge clk) rd_pend <= rd_req;

   always @(negedge clk) begin
      if (rst_n && start) begin
         checks++;
         if (start_exp_q.size() == 0) begin
            errors++;
            $display("FAIL start_unexpected actual_cycle=%0d required=no_pulse", cyc);
         end else begin
            e_cyc = start_exp_q.pop_front();
            if (32'(cyc) !== e_cyc) begin
               errors++;
               $display("FAIL start_cycle actual=%0d required=%0d", cyc, e_cyc);
            end
         end
      end
      if (rst_n && tx_start) begin
         checks++;
         if (tx_cyc_q.size() == 0) begin
            errors++;
            $display("FAIL tx_unexpected actual_cycle=%0d data=%0h required=no_pulse", cyc, tx_data);
         end else begin
            e_cyc = tx_cyc_q.pop_front();
            e_dat = tx_data_q.pop_front();
            if ((32'(cyc) !== e_cyc) || (tx_data !== e_dat)) begin
               errors++;
               $display("FAIL tx_pulse actual cycle=%0d data=%0h required cycle=%0d data=%0h",
                        cyc, tx_data, e_cyc, e_dat);
            end
         end
      end
      if (rst_n && rd_pend) begin
         checks++;
         if (q_exp_q.size() == 0) begin
            errors++;
            $display("FAIL q_read_unexpected actual=%0b", q_input);
         end else begin
            e_bit = q_exp_q.pop_front();
            if (q_input !== e_bit[0]) begin
               errors++;
               $display("FAIL q_read addr=%0d actual=%0b required=%0b", 32'(addr_input_unit) - 1,
                        q_input, e_bit);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data     = b;
      rx_rdy      = 1'b1;
      last_rx_cyc = cyc;
      tick(1);
      rx_rdy      = 1'b0;
   endtask

   task automatic send_range(input int first, input int last, input int spacing);
      for (int k = first; k <= last; k++) begin
         send_byte(img[k]);
         if (k != last) tick(spacing - 1);
      end
   endtask

   // Back-to-back reads; each result is checked one cycle after its address.
   task automatic sweep();
      for (int a = 0; a < NUM_PIXELS; a++) begin
         addr_input_unit = 10'(a);
         rd_req          = 1'b1;
         q_exp_q.push_back(img[a / 8][a % 8]);
         tick(1);
      end
      rd_req = 1'b0;
      tick(2);
   endtask

   task automatic finish_frame(input logic [3:0] d);
      digit     = d;
      core_done = 1'b1;
      tx_cyc_q.push_back(32'(cyc + 2));
      tx_data_q.push_back(exp_tx(d));
      tick(4);
      core_done = 1'b0;
      tick(3);
      chk("busy_wait_tx", busy, 1);
      tx_done = 1'b1;
      tick(1);
      tx_done = 1'b0;
      chk("busy_after_tx_done", busy, 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst_n = 1'b0; rx_rdy = 1'b0; rx_data = 8'h00; addr_input_unit = 10'd0;
      core_done = 1'b0; digit = 4'd0; tx_done = 1'b0;
      tick(3);
      chk("rst_q_input", q_input, 0);
      chk("rst_start", start, 0);
      chk("rst_tx_start", tx_start, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ovr", ovr, 0);
      rst_n = 1'b1;
      tick(2);

      // Frame A: byte k = k, spacing 20, then full read sweep
      for (int k = 0; k < NUM_BYTES; k++) img[k] = 8'(k);
      send_range(0, NUM_BYTES - 1, 20);
      start_exp_q.push_back(32'(last_rx_cyc + 9));
      tick(12);
      chk("a_busy_run", busy, 1);
      chk("a_ovr_clean", ovr, 0);
      sweep();

      // Byte during RUN is dropped and flags overrun, RAM untouched
      send_byte(8'hAA);
      chk("run_rx_ovr", ovr, 1);
      chk("run_rx_busy", busy, 1);
      sweep();
      finish_frame(4'd7);
      chk("ovr_sticky", ovr, 1);

      // Frame B: bytes every 2 cycles, hold absorbs one, third overruns
      for (int k = 0; k < NUM_BYTES; k++) img[k] = 8'(k * 7 + 3);
      img[0] = 8'h5A;
      img[1] = 8'hC3;
      send_byte(img[0]);
      chk("b_ovr_cleared_new_frame", ovr, 0);
      chk("b_busy_unpack", busy, 1);
      tick(1);
      send_byte(img[1]);
      chk("b_hold_no_ovr", ovr, 0);
      tick(1);
      send_byte(8'h99);
      chk("b_third_byte_ovr", ovr, 1);
      tick(20);
      chk("b_idle_after_two", busy, 0);
      send_range(2, NUM_BYTES - 1, 20);
      start_exp_q.push_back(32'(last_rx_cyc + 9));
      tick(12);
      sweep();
      finish_frame(4'd3);

      // Frame C: abandon after 50 bytes via reset, then reload all-ones
      send_byte(8'h00);
      chk("c_ovr_cleared_new_frame", ovr, 0);
      tick(11);
      for (int k = 1; k < 50; k++) begin
         send_byte(8'h00);
         tick(11);
      end
      send_byte(8'h0F);
      rst_n = 1'b0;
      tick(1);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_tx_data", tx_data, 0);
      chk("mid_rst_start", start, 0);
      chk("mid_rst_ovr", ovr, 0);
      rst_n = 1'b1;
      tick(2);
      for (int k = 0; k < NUM_BYTES; k++) img[k] = 8'hFF;
      send_range(0, NUM_BYTES - 1, 12);
      start_exp_q.push_back(32'(last_rx_cyc + 9));
      tick(12);
      chk("c_ovr_clean", ovr, 0);
      sweep();
      finish_frame(4'd0);

      // Frame D: core_done already high before start
      for (int k = 0; k < NUM_BYTES; k++) img[k] = 8'(k) ^ 8'h3C;
      send_range(0, NUM_BYTES - 2, 12);
      tick(11);
      digit     = 4'd9;
      core_done = 1'b1;
      send_byte(img[NUM_BYTES - 1]);
      start_exp_q.push_back(32'(last_rx_cyc + 9));
      tx_cyc_q.push_back(32'(last_rx_cyc + 12));
      tx_data_q.push_back(exp_tx(4'd9));
      tick(16);
      core_done = 1'b0;
      tick(3);
      chk("d_busy_wait_tx", busy, 1);
      tx_done = 1'b1;
      tick(1);
      tx_done = 1'b0;
      chk("d_busy_after_tx_done", busy, 0);
      tick(20);

      chk("start_q_drained", start_exp_q.size(), 0);
      chk("tx_q_drained", tx_cyc_q.size(), 0);
      chk("q_read_q_drained", q_exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
